// File: rtl/p_mul_out_serializer_if.sv
// Bus between the 96-bit multiplier output, the serializer and the narrow output port.
interface p_mul_out_serializer_if #(
  parameter int DEPTH = 4,
  parameter int OUT_W = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic [95:0]      in;
  logic             out_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
  logic             overflow;
  logic [CW-1:0]    fifo_count;

  modport slave (
    input  in_valid, in, out_ready,
    output out_valid, out_data, out_last, overflow, fifo_count
  );

  modport master (
    output in_valid, in, out_ready,
    input  out_valid, out_data, out_last, overflow, fifo_count
  );
endinterface

// File: rtl/p_mul_out_serializer.sv
// Buffers 96-bit products in a small FIFO and streams each one out as OUT_W-bit beats, MSB first.
//
// state | meaning
// IDLE  | nothing being sent; out_valid=0, waits for a queued product
// SEND  | head product on the bus, one beat per handshake
module p_mul_out_serializer #(
  parameter int DEPTH = 4,
  parameter int OUT_W = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  p_mul_out_serializer_if.slave bus
);
  localparam int BEATS = 96 / OUT_W;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state_q, state_d;
  logic [95:0]      mem_q [DEPTH];
  logic [95:0]      mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             overflow_q, overflow_d;

  logic             full, pop, wr, drop;
  logic [AW-1:0]    rd_nx;
  logic [BW-1:0]    beat_nx;
  logic [95:0]      head, nxt_head;

  function automatic logic [OUT_W-1:0] chunk(input logic [95:0] e, input int k);
    return e[95 - k*OUT_W -: OUT_W];
  endfunction

  assign full     = (count_q == CW'(DEPTH));
  assign pop      = (state_q == SEND) && out_valid_q && bus.out_ready && out_last_q;
  assign wr       = bus.in_valid && (!full || pop);
  assign drop     = bus.in_valid && full && !pop;
  assign rd_nx    = rd_ptr_q + AW'(1);
  assign beat_nx  = beat_q + BW'(1);
  assign head     = mem_q[rd_ptr_q];
  // With one entry left, the next head can only be the product arriving this cycle.
  assign nxt_head = (count_q == CW'(1)) ? bus.in : mem_q[rd_nx];

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    beat_d      = beat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    overflow_d  = overflow_q;

    if (wr) begin
      mem_d[wr_ptr_q] = bus.in;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (drop) overflow_d = 1'b1;

    case ({wr, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d     = SEND;
          beat_d      = '0;
          out_valid_d = 1'b1;
          out_data_d  = chunk(head, 0);
          out_last_d  = 1'(BEATS == 1);
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          if (out_last_q) begin
            rd_ptr_d = rd_nx;
            if (count_d != '0) begin
              beat_d     = '0;
              out_data_d = chunk(nxt_head, 0);
              out_last_d = 1'(BEATS == 1);
            end else begin
              state_d     = IDLE;
              out_valid_d = 1'b0;
              out_data_d  = '0;
              out_last_d  = 1'b0;
            end
          end else begin
            beat_d     = beat_nx;
            out_data_d = chunk(head, int'(beat_nx));
            out_last_d = (beat_nx == BW'(BEATS - 1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      beat_q      <= beat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      overflow_q  <= overflow_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_p_mul_out_serializer.sv
// Directed bench for p_mul_out_serializer: cycle vector table plus hand-written corner sequences.
module tb_p_mul_out_serializer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  p_mul_out_serializer_if #(.DEPTH(4), .OUT_W(16)) bus ();
  p_mul_out_serializer #(.DEPTH(4), .OUT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [95:0] din;
    logic        rdy;
    logic        ev;
    logic [15:0] ed;
    logic        el;
    logic [2:0]  ec;
  } vec_t;

  vec_t vecs[$];
  localparam logic [95:0] PSPEC = 96'h0123_4567_89AB_CDEF_0011_2233;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [95:0] din, input logic rdy,
                     input logic ev, input logic [15:0] ed, input logic el, input logic [2:0] ec);
    vec_t v;
    v.iv = iv; v.din = din; v.rdy = rdy; v.ev = ev; v.ed = ed; v.el = el; v.ec = ec;
    vecs.push_back(v);
  endtask

  function automatic logic [95:0] mk(input int k);
    logic [95:0] r;
    for (int b = 0; b < 6; b++) r[95 - 16*b -: 16] = {4'(k), 12'(b)};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
  endtask

  // Holds out_ready high and expects nprod products mk(first_k).. back to back.
  task automatic collect(input string name, input int first_k, input int nprod);
    int total, idx, cyc;
    total = 6 * nprod; idx = 0; cyc = 0;
    bus.out_ready = 1'b1;
    while (idx < total && cyc < total + 20) begin
      if (bus.out_valid) begin
        chk({name, "_data"}, 96'(bus.out_data), 96'({4'(first_k + idx / 6), 12'(idx % 6)}));
        chk({name, "_last"}, 96'(bus.out_last), 96'((idx % 6) == 5));
        idx++;
      end
      step();
      cyc++;
    end
    if (idx < total) chk({name, "_timeout_beats"}, 96'(idx), 96'(total));
  endtask

  initial begin
    logic [15:0] spec_w [6];
    int n;
    spec_w = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h0011, 16'h2233};

    // single product
    add(1, PSPEC, 1, 0, 16'h0, 0, 1);
    for (int b = 0; b < 6; b++) add(0, '0, 1, 1, spec_w[b], b == 5, 1);
    add(0, '0, 1, 0, 16'h0, 0, 0);
    // back-to-back, no bubble between products
    add(1, 96'h1, 1, 0, 16'h0, 0, 1);
    add(1, 96'h2, 1, 1, 16'h0, 0, 2);
    for (int b = 1; b < 6; b++) add(0, '0, 1, 1, (b == 5) ? 16'h1 : 16'h0, b == 5, 2);
    for (int b = 0; b < 6; b++) add(0, '0, 1, 1, (b == 5) ? 16'h2 : 16'h0, b == 5, 1);
    add(0, '0, 1, 0, 16'h0, 0, 0);

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in = '0; bus.out_ready = 1'b0;
    #2;
    chk("rst_valid", 96'(bus.out_valid), 96'(0));
    chk("rst_data", 96'(bus.out_data), 96'(0));
    chk("rst_last", 96'(bus.out_last), 96'(0));
    chk("rst_ovf", 96'(bus.overflow), 96'(0));
    chk("rst_count", 96'(bus.fifo_count), 96'(0));
    do_reset();

    foreach (vecs[i]) begin
      bus.in_valid = vecs[i].iv; bus.in = vecs[i].din; bus.out_ready = vecs[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), 96'(bus.out_valid), 96'(vecs[i].ev));
      chk($sformatf("vec%0d_count", i), 96'(bus.fifo_count), 96'(vecs[i].ec));
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_data", i), 96'(bus.out_data), 96'(vecs[i].ed));
        chk($sformatf("vec%0d_last", i), 96'(bus.out_last), 96'(vecs[i].el));
      end
    end
    chk("vec_ovf", 96'(bus.overflow), 96'(0));

    // backpressure holds beat 0
    do_reset();
    bus.in_valid = 1'b1; bus.in = PSPEC; step();
    bus.in_valid = 1'b0; bus.in = '0; step();
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid", 96'(bus.out_valid), 96'(1));
      chk("bp_hold_data", 96'(bus.out_data), 96'(16'h0123));
      step();
    end
    bus.out_ready = 1'b1;
    for (int b = 0; b < 6; b++) begin
      chk("bp_valid", 96'(bus.out_valid), 96'(1));
      chk("bp_data", 96'(bus.out_data), 96'(spec_w[b]));
      chk("bp_last", 96'(bus.out_last), 96'(b == 5));
      step();
    end
    chk("bp_idle", 96'(bus.out_valid), 96'(0));

    // overflow: fifth product dropped
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1; bus.in = mk(k); step();
    end
    bus.in_valid = 1'b0; bus.in = '0;
    chk("ovf_count", 96'(bus.fifo_count), 96'(4));
    chk("ovf_flag", 96'(bus.overflow), 96'(1));
    collect("ovf", 0, 4);
    chk("ovf_idle", 96'(bus.out_valid), 96'(0));
    chk("ovf_count_end", 96'(bus.fifo_count), 96'(0));
    chk("ovf_sticky", 96'(bus.overflow), 96'(1));

    // full with write on the same cycle as the last-beat pop
    do_reset();
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1; bus.in = mk(k); step();
    end
    bus.in_valid = 1'b0; bus.in = '0;
    chk("fp_count_full", 96'(bus.fifo_count), 96'(4));
    bus.out_ready = 1'b1;
    n = 0;
    while (!bus.out_last && n < 20) begin step(); n++; end
    chk("fp_last_seen", 96'(bus.out_last), 96'(1));
    chk("fp_last_data", 96'(bus.out_data), 96'(16'h0005));
    bus.in_valid = 1'b1; bus.in = mk(4); step();
    bus.in_valid = 1'b0; bus.in = '0;
    chk("fp_count", 96'(bus.fifo_count), 96'(4));
    chk("fp_ovf", 96'(bus.overflow), 96'(0));
    chk("fp_valid", 96'(bus.out_valid), 96'(1));
    collect("fp", 1, 4);
    chk("fp_ovf_end", 96'(bus.overflow), 96'(0));
    chk("fp_count_end", 96'(bus.fifo_count), 96'(0));

    // reset during beat 3 with two entries queued
    do_reset();
    bus.in_valid = 1'b1; bus.in = mk(6); step();
    bus.in = mk(7); step();
    bus.in_valid = 1'b0; bus.in = '0;
    bus.out_ready = 1'b1;
    n = 0;
    while (!(bus.out_valid && bus.out_data == 16'h6003) && n < 20) begin step(); n++; end
    chk("mr_reach_beat3", 96'(bus.out_data), 96'(16'h6003));
    chk("mr_count_pre", 96'(bus.fifo_count), 96'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", 96'(bus.out_valid), 96'(0));
    chk("mr_data", 96'(bus.out_data), 96'(0));
    chk("mr_last", 96'(bus.out_last), 96'(0));
    chk("mr_count", 96'(bus.fifo_count), 96'(0));
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("mr_stay_idle", 96'(bus.out_valid), 96'(0));
    end
    bus.in_valid = 1'b1; bus.in = mk(8); step();
    bus.in_valid = 1'b0; bus.in = '0;
    collect("mr_new", 8, 1);
    chk("mr_idle_end", 96'(bus.out_valid), 96'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
